// File: rtl/enc_arb_pkg.sv
// Shared types and defaults for the enc_* round-robin access arbiter.
//   arb_state_e  : arbiter FSM state (IDLE, GRANT)
//   DEF_NUM_REQ  : default requester count
//   DEF_MAX_HOLD : default grant-cycle limit before a forced rotation
//   idx_w()      : binary index width needed for n requesters
package enc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 15;
  localparam int DEF_MAX_HOLD = 16;

  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/enc_rr_onehot_arb_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
//   req        : level request per requester
//   done       : current grantee finishes this cycle
//   gnt_valid  : a grant is active
//   gnt_idx    : binary index of the grantee (0 when idle)
//   gnt_onehot : one-hot of gnt_idx (0 when idle)
//   timeout    : one-cycle pulse on a forced rotation
// Modports: master = requester side, slave = arbiter side.
interface enc_rr_onehot_arb_if
  import enc_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
);

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt_valid, gnt_idx, gnt_onehot, timeout
  );

  modport slave (
    input  req, done,
    output gnt_valid, gnt_idx, gnt_onehot, timeout
  );

endinterface

// File: rtl/enc_idx_onehot_dec.sv
// Binary index + valid to one-hot expansion (purely combinational).
//   idx    : binary index
//   valid  : qualifies idx; output is all-zero when low
//   onehot : NUM_REQ-wide one-hot of idx
module enc_idx_onehot_dec
  import enc_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic               valid,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot[i] = valid && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/enc_rr_onehot_arb.sv
// Round-robin arbiter scheduling the enc_* encoder datapaths onto one shared
// resource. The winner keeps the grant until it signals done or drops its
// request; priority then rotates to the requester after it.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : enc_rr_onehot_arb_if.slave (req, done in; gnt_* and timeout out)
// Optional feature: define ARB_TIMEOUT_EN to force a rotation after MAX_HOLD
// grant cycles whenever another requester is waiting (timeout pulses once).
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// GRANT | gnt_idx owns the resource
module enc_rr_onehot_arb
  import enc_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int IDX_W    = idx_w(NUM_REQ),
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input logic                  clk,
  input logic                  rst,
  enc_rr_onehot_arb_if.slave   bus
);

  if (NUM_REQ < 2 || NUM_REQ > 15 || MAX_HOLD < 2 || IDX_W < idx_w(NUM_REQ)) begin : g_bad_cfg
    $error("enc_rr_onehot_arb: unsupported parameter set");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [NUM_REQ-1:0] others;
  logic [IDX_W-1:0]   ptr_next;
  logic               release_nat, release_any;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               hold_max, forced;
  logic               timeout_q, timeout_d;
`endif

  // Lowest set bit at or above start; if none, lowest set bit overall (wrap).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDX_W-1:0]   start);
    logic [NUM_REQ-1:0] upper;
    logic [IDX_W-1:0]   win;
    upper = '0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = mask[i] && (IDX_W'(i) >= start);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if ((upper != '0) ? upper[i] : mask[i]) win = IDX_W'(i);
    end
    return win;
  endfunction

  enc_idx_onehot_dec #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_dec (
    .idx    (gnt_idx_q),
    .valid  (gnt_valid_q),
    .onehot (gnt_onehot)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    // The releasing grantee never competes in the back-to-back search.
    others      = bus.req & ~gnt_onehot;
    release_nat = bus.done || ((bus.req & gnt_onehot) == '0);
    ptr_next    = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    hold_max    = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    forced      = hold_max && (others != '0) && !release_nat;
    release_any = release_nat || forced;
`else
    release_any = release_nat;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = rr_pick(bus.req, ptr_q);
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (release_any) begin
          ptr_d = ptr_next;
          if (others != '0) begin
            gnt_idx_d = rr_pick(others, ptr_next);
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            gnt_idx_d   = '0;
          end
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
          timeout_d  = forced;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          // Saturate when nobody else is waiting so the grant can continue.
          if (!hold_max) hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule
